// File: rtl/shift_unit_pkg.sv
// Shared mode codes and FSM state encoding for the multi-cycle shifter.
// Codes 101-111 are reserved and behave as HOLD.
package shift_unit_pkg;

  typedef enum logic [2:0] {
    MODE_LSL = 3'b000,
    MODE_LSR = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of d; out_bit is the bit that leaves the word.
// Purely combinational; unknown modes pass d through with out_bit = 0.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  always_comb begin
    q       = d;
    out_bit = 1'b0;
    case (mode)
      MODE_LSL: begin
        q       = {d[WIDTH-2:0], fill};
        out_bit = d[WIDTH-1];
      end
      MODE_LSR: begin
        q       = {fill, d[WIDTH-1:1]};
        out_bit = d[0];
      end
      MODE_ASR: begin
        q       = {d[WIDTH-1], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      MODE_ROL: begin
        q       = {d[WIDTH-2:0], d[WIDTH-1]};
        out_bit = d[WIDTH-1];
      end
      MODE_ROR: begin
        q       = {d[0], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      default: begin
        q       = d;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: one bit position per cycle, N shifts take N cycles after acceptance.
// start is ignored while busy; done pulses for one cycle after the last shift (or directly for N=0).
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fill_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic [AW-1:0]    r_count;
  logic [2:0]       r_mode;
  logic             r_fill;
  logic             w_accept;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_out;

  assign w_accept  = start && (r_state != ST_SHIFT);
  assign data_out  = r_data;
  assign carry_out = r_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode    (r_mode),
    .fill    (r_fill),
    .d       (r_data),
    .q       (w_step_q),
    .out_bit (w_step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (amount != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        // count still holds the pre-decrement value on the edge doing the last shift
        if (r_count == AW'(1)) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_next_state = (amount != '0) ? ST_SHIFT : ST_DONE;
        else       w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_mode  <= '0;
      r_fill  <= 1'b0;
    end else if (w_accept) begin
      r_data  <= data_in;
      r_carry <= 1'b0;
      r_count <= amount;
      r_mode  <= mode;
      r_fill  <= fill_in;
    end else if (r_state == ST_SHIFT) begin
      r_data  <= w_step_q;
      r_carry <= w_step_out;
      r_count <= r_count - AW'(1);
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit (WIDTH=16): closed-form reference model checked every cycle,
// directed vectors with literal expectations, then randomized traffic.
module tb_shift_unit;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [3:0]    amount;
  logic [W-1:0]  data_in;
  logic          fill_in;
  logic [W-1:0]  data_out;
  logic          carry_out;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int g_dones  = 0;
  bit chk_en   = 0;
  logic [W-1:0] hist [0:39];

  shift_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .amount    (amount),
    .data_in   (data_in),
    .fill_in   (fill_in),
    .data_out  (data_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result of applying j single-position steps to d, in closed form.
  function automatic logic [W-1:0] ref_data(input logic [2:0] md, input logic [W-1:0] d,
                                            input logic f, input int j);
    logic [31:0]         x;
    logic [31:0]         lo;
    logic signed [W-1:0] s;
    x  = {16'h0, d};
    lo = (32'd1 << j) - 32'd1;
    s  = d;
    if (j == 0) return d;
    case (md)
      3'd0:    return W'((x << j) | (f ? lo : 32'd0));
      3'd1:    return W'((x >> j) | (f ? (lo << (W - j)) : 32'd0));
      3'd2:    return W'(s >>> j);
      3'd3:    return W'((x << j) | (x >> (W - j)));
      3'd4:    return W'((x >> j) | (x << (W - j)));
      default: return d;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [2:0] md, input logic [W-1:0] d,
                                     input logic f, input int j);
    logic [W-1:0] r;
    r = ref_data(md, d, f, j);
    if (j == 0) return 1'b0;
    case (md)
      3'd0:    return d[W-j];
      3'd1:    return d[j-1];
      3'd2:    return d[j-1];
      3'd3:    return r[0];
      3'd4:    return r[W-1];
      default: return 1'b0;
    endcase
  endfunction

  // Model: phase 0 idle, 1 shifting, 2 done; m_j = shifts performed so far.
  int           m_phase = 0;
  logic [2:0]   m_mode  = '0;
  logic [W-1:0] m_d     = '0;
  logic         m_fill  = 1'b0;
  int           m_n     = 0;
  int           m_j     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_d = '0; m_j = 0; m_n = 0; m_mode = '0; m_fill = 1'b0;
    end else if (m_phase == 1) begin
      m_j++;
      if (m_j == m_n) m_phase = 2;
    end else if (start) begin
      m_mode = mode; m_d = data_in; m_fill = fill_in; m_n = int'(amount); m_j = 0;
      m_phase = (m_n > 0) ? 1 : 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (done) g_dones++;
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_phase == 1));
      chk("cyc_done", 32'(done), 32'(m_phase == 2));
      chk("cyc_data", 32'(data_out), 32'(ref_data(m_mode, m_d, m_fill, m_j)));
      chk("cyc_carry", 32'(carry_out), 32'(ref_carry(m_mode, m_d, m_fill, m_j)));
      chk("cyc_busy_and_done", 32'(busy && done), 32'd0);
    end
  end

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hist[i] = data_out;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] md, input logic [W-1:0] d,
                        input int n, input logic f, input logic [W-1:0] ed, input logic ec);
    int lat;
    @(posedge clk); #2;
    start = 1'b1; mode = md; data_in = d; amount = 4'(n); fill_in = f;
    @(posedge clk); #2;
    start = 1'b0; fill_in = ~f; data_in = W'($urandom); mode = 3'($urandom_range(0, 7));
    wait_done(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(n));
    chk({nm, "_data"}, 32'(data_out), 32'(ed));
    chk({nm, "_carry"}, 32'(carry_out), 32'(ec));
  endtask

  initial begin
    int lat;
    int dn;
    int d0;
    rst = 1'b1; start = 1'b0; mode = '0; amount = '0; data_in = '0; fill_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_carry", 32'(carry_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk_en = 1'b1;

    chk("model_lsl", 32'(ref_data(3'd0, 16'hB76B, 1'b0, 4)), 32'h76B0);
    chk("model_lsl_c", 32'(ref_carry(3'd0, 16'hB76B, 1'b0, 4)), 32'h1);
    chk("model_asr", 32'(ref_data(3'd2, 16'h8001, 1'b0, 3)), 32'hF000);
    chk("model_ror", 32'(ref_data(3'd4, 16'h0001, 1'b0, 15)), 32'h0002);
    chk("model_lsr_fill", 32'(ref_data(3'd1, 16'h00F0, 1'b1, 4)), 32'hF00F);

    run_op("lsl4", 3'd0, 16'hB76B, 4, 1'b0, 16'h76B0, 1'b1);
    run_op("asr3", 3'd2, 16'h8001, 3, 1'b0, 16'hF000, 1'b0);
    chk("asr3_step1", 32'(hist[1]), 32'hC000);
    chk("asr3_step2", 32'(hist[2]), 32'hE000);
    run_op("ror15", 3'd4, 16'h0001, 15, 1'b0, 16'h0002, 1'b0);
    run_op("lsr4_fill1", 3'd1, 16'h00F0, 4, 1'b1, 16'hF00F, 1'b0);
    run_op("lsr0", 3'd1, 16'h1234, 0, 1'b0, 16'h1234, 1'b0);
    run_op("hold5", 3'd6, 16'hA5A5, 5, 1'b1, 16'hA5A5, 1'b0);
    run_op("rol4", 3'd3, 16'h8421, 4, 1'b0, 16'h4218, 1'b0);

    // start during SHIFT is ignored, then reset aborts the operation
    @(posedge clk); #2;
    start = 1'b1; mode = 3'd0; data_in = 16'hFFFF; amount = 4'd8; fill_in = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; mode = 3'd1; data_in = 16'h1111; amount = 4'd0;
    @(posedge clk); #2;
    start = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'h1);
    chk("abort_ignored_start", 32'(data_out), 32'hFFFE);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_data", 32'(data_out), 32'h0);
    chk("abort_carry", 32'(carry_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'h0);

    // back-to-back: new start accepted while in DONE
    d0 = g_dones;
    @(posedge clk); #2;
    start = 1'b1; mode = 3'd3; data_in = 16'h8001; amount = 4'd2; fill_in = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(lat);
    chk("b2b_a_latency", 32'(lat), 32'd2);
    chk("b2b_a_data", 32'(data_out), 32'h0006);
    #1;
    start = 1'b1; mode = 3'd1; data_in = 16'h8000; amount = 4'd1; fill_in = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(lat);
    chk("b2b_b_latency", 32'(lat), 32'd1);
    chk("b2b_b_data", 32'(data_out), 32'h4000);
    repeat (4) @(negedge clk);
    chk("b2b_done_pulses", 32'(g_dones - d0), 32'd2);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      start   = ($urandom_range(0, 3) == 0);
      mode    = 3'($urandom_range(0, 7));
      amount  = 4'($urandom_range(0, 15));
      data_in = W'($urandom);
      fill_in = 1'($urandom);
      rst     = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; rst = 1'b0;
    repeat (20) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
